// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and helpers for the long-packet AXI-Stream FIFO.
package axis_pkt_fifo_pkg;

   typedef logic [15:0] len_t;

   // One entry per stored packet; len_m1 is the index of the last beat.
   typedef struct packed {
      logic len_is_1;
      len_t len_m1;
   } pkt_desc_t;

   function automatic int addr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/sc_delay_line.sv
// Fixed-latency shift register; LAT=0 collapses to a wire.
module sc_delay_line #(
   parameter int LAT   = 6,
   parameter int DSIZE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DSIZE-1:0] din,
   output logic [DSIZE-1:0] dout
);

   generate
      if (LAT == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst_n;
         assign dout = din;
      end else begin : g_sr
         logic [DSIZE-1:0] sr [LAT];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < LAT; i++) sr[i] <= '0;
            end else begin
               sr[0] <= din;
               for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
            end
         end

         assign dout = sr[LAT-1];
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
module sync_fifo_fwft
   import axis_pkt_fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = addr_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_do;
   logic             rd_do;

   assign wr_do = wr_en && !full;
   assign rd_do = rd_en && !empty;

   // The extra pointer MSB separates full from empty once the pointers wrap.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_do) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_do) wr_ptr <= wr_ptr + 1'b1;
         if (rd_do) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/axis_packet_long_fifo_sc.sv
// Store-and-forward AXI-Stream packet FIFO: packets leave only once complete
// and released; output tlast is rebuilt from stored packet lengths.
module axis_packet_long_fifo_sc
   import axis_pkt_fifo_pkg::*;
#(
   parameter int DSIZE     = 32,
   parameter int KSIZE     = DSIZE / 8,
   parameter int USE_KEEP  = 0,
   parameter int DEPTH     = 8192,
   parameter int PKT_DEPTH = 4,
   parameter int REL_LAT   = 6
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic [DSIZE-1:0] in_tdata,
   input  logic [KSIZE-1:0] in_tkeep,
   input  logic             in_tvalid,
   input  logic             in_tlast,
   output logic             in_tready,
   output logic [DSIZE-1:0] out_tdata,
   output logic [KSIZE-1:0] out_tkeep,
   output logic             out_tvalid,
   output logic             out_tlast,
   input  logic             out_tready,
   output logic             err_too_long
);

   localparam int PKT_D_MIN = (PKT_DEPTH < 4) ? 4 : PKT_DEPTH;
   localparam int PKT_D     = 1 << addr_w(PKT_D_MIN);
   localparam int DW        = (USE_KEEP != 0) ? DSIZE + KSIZE : DSIZE;

   logic          data_full, data_empty;
   logic          pkt_full, pkt_empty;
   logic [DW-1:0] wr_word, rd_word;
   pkt_desc_t     wr_desc, rd_desc;
   len_t          w_cnt, r_cnt;
   logic [15:0]   rel_cnt;
   logic          wr_fire, rd_fire, last_wr, last_rd, rel_pulse;

   // A beat moves on either side only in a cycle where valid and ready are
   // both high; ready never looks at valid, and valid never looks at ready.
   assign in_tready  = !data_full && !pkt_full;
   assign wr_fire    = in_tvalid && in_tready;
   assign out_tvalid = (rel_cnt != '0) && !pkt_empty && !data_empty;
   assign rd_fire    = out_tvalid && out_tready;
   assign last_wr    = wr_fire && in_tlast;
   assign last_rd    = rd_fire && out_tlast;

   assign wr_desc.len_is_1 = (w_cnt == '0);
   assign wr_desc.len_m1   = w_cnt;

   // Gated by !pkt_empty so an empty length FIFO never reports a last beat.
   assign out_tlast = !pkt_empty && (rd_desc.len_is_1 || (r_cnt == rd_desc.len_m1));

   generate
      if (USE_KEEP != 0) begin : g_keep
         assign wr_word   = {in_tkeep, in_tdata};
         assign out_tkeep = rd_word[DW-1:DSIZE];
      end else begin : g_no_keep
         logic unused_keep;
         assign unused_keep = ^in_tkeep;
         assign wr_word     = in_tdata;
         assign out_tkeep   = data_empty ? '0 : '1;
      end
   endgenerate

   assign out_tdata = rd_word[DSIZE-1:0];

   sync_fifo_fwft #(.WIDTH(DW), .DEPTH(DEPTH)) u_data_fifo (
      .clk     (aclk),
      .rst_n   (aresetn),
      .wr_en   (wr_fire),
      .wr_data (wr_word),
      .rd_en   (rd_fire),
      .rd_data (rd_word),
      .full    (data_full),
      .empty   (data_empty)
   );

   sync_fifo_fwft #(.WIDTH($bits(pkt_desc_t)), .DEPTH(PKT_D)) u_len_fifo (
      .clk     (aclk),
      .rst_n   (aresetn),
      .wr_en   (last_wr),
      .wr_data (wr_desc),
      .rd_en   (last_rd),
      .rd_data (rd_desc),
      .full    (pkt_full),
      .empty   (pkt_empty)
   );

   sc_delay_line #(.LAT(REL_LAT), .DSIZE(1)) u_rel_dly (
      .clk   (aclk),
      .rst_n (aresetn),
      .din   (last_wr),
      .dout  (rel_pulse)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_cnt        <= '0;
         r_cnt        <= '0;
         rel_cnt      <= '0;
         err_too_long <= 1'b0;
      end else begin
         if (wr_fire) w_cnt <= in_tlast ? '0 : w_cnt + 16'd1;
         if (rd_fire) r_cnt <= out_tlast ? '0 : r_cnt + 16'd1;

         case ({rel_pulse, last_rd})
            2'b10:   rel_cnt <= rel_cnt + 16'd1;
            2'b01:   rel_cnt <= rel_cnt - 16'd1;
            default: rel_cnt <= rel_cnt;
         endcase

         // Full with nothing releasable and a packet still open: it can never fit.
         if (data_full && (rel_cnt == '0) && (w_cnt != '0)) err_too_long <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_packet_long_fifo_sc.sv
// Directed bench for axis_packet_long_fifo_sc: a default-size instance and a
// 16-word instance with stored tkeep and zero release latency.
module tb_axis_packet_long_fifo_sc;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] a_in_tdata, a_out_tdata, b_in_tdata, b_out_tdata;
   logic [3:0]  a_in_tkeep, a_out_tkeep, b_in_tkeep, b_out_tkeep;
   logic        a_in_tvalid, a_in_tlast, a_in_tready, a_out_tvalid, a_out_tlast, a_out_tready, a_err;
   logic        b_in_tvalid, b_in_tlast, b_in_tready, b_out_tvalid, b_out_tlast, b_out_tready, b_err;

   axis_packet_long_fifo_sc #(.DSIZE(32), .USE_KEEP(0), .DEPTH(8192), .PKT_DEPTH(4), .REL_LAT(6)) dut_a (
      .aclk(clk), .aresetn(rst_n),
      .in_tdata(a_in_tdata), .in_tkeep(a_in_tkeep), .in_tvalid(a_in_tvalid),
      .in_tlast(a_in_tlast), .in_tready(a_in_tready),
      .out_tdata(a_out_tdata), .out_tkeep(a_out_tkeep), .out_tvalid(a_out_tvalid),
      .out_tlast(a_out_tlast), .out_tready(a_out_tready), .err_too_long(a_err)
   );

   axis_packet_long_fifo_sc #(.DSIZE(32), .USE_KEEP(1), .DEPTH(16), .PKT_DEPTH(2), .REL_LAT(0)) dut_b (
      .aclk(clk), .aresetn(rst_n),
      .in_tdata(b_in_tdata), .in_tkeep(b_in_tkeep), .in_tvalid(b_in_tvalid),
      .in_tlast(b_in_tlast), .in_tready(b_in_tready),
      .out_tdata(b_out_tdata), .out_tkeep(b_out_tkeep), .out_tvalid(b_out_tvalid),
      .out_tlast(b_out_tlast), .out_tready(b_out_tready), .err_too_long(b_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   logic        exp_l[$];
   logic [3:0]  exp_k[$];
   logic [31:0] got_d[$];
   logic        got_l[$];
   logic [3:0]  got_k[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      exp_q.delete(); exp_l.delete(); exp_k.delete();
      got_d.delete(); got_l.delete(); got_k.delete();
   endtask

   task automatic a_send(input logic [31:0] d, input logic l);
      int t = 0;
      a_in_tdata = d; a_in_tlast = l; a_in_tvalid = 1'b1;
      while (!a_in_tready && t < 300) begin step(); t++; end
      check("a_send_ready", a_in_tready, 1'b1);
      step();
      a_in_tvalid = 1'b0; a_in_tlast = 1'b0;
   endtask

   task automatic b_send(input logic [31:0] d, input logic [3:0] k, input logic l);
      int t = 0;
      b_in_tdata = d; b_in_tkeep = k; b_in_tlast = l; b_in_tvalid = 1'b1;
      while (!b_in_tready && t < 300) begin step(); t++; end
      check("b_send_ready", b_in_tready, 1'b1);
      step();
      b_in_tvalid = 1'b0; b_in_tlast = 1'b0;
   endtask

   task automatic a_recv(input int n, input bit rnd);
      int t = 0;
      while (got_d.size() < n && t < 2000) begin
         a_out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (a_out_tvalid && a_out_tready) begin
            got_d.push_back(a_out_tdata);
            got_l.push_back(a_out_tlast);
            got_k.push_back(a_out_tkeep);
         end
         step(); t++;
      end
      a_out_tready = 1'b0;
      check("a_recv_count", 64'(got_d.size()), 64'(n));
   endtask

   task automatic b_recv(input int n);
      int t = 0;
      while (got_d.size() < n && t < 2000) begin
         b_out_tready = 1'b1;
         if (b_out_tvalid) begin
            got_d.push_back(b_out_tdata);
            got_l.push_back(b_out_tlast);
            got_k.push_back(b_out_tkeep);
         end
         step(); t++;
      end
      b_out_tready = 1'b0;
      check("b_recv_count", 64'(got_d.size()), 64'(n));
   endtask

   task automatic compare(input string tag);
      for (int i = 0; i < got_d.size(); i++) begin
         check({tag, "_data"}, got_d[i], exp_q[i]);
         check({tag, "_last"}, got_l[i], exp_l[i]);
         check({tag, "_keep"}, got_k[i], exp_k[i]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      a_in_tdata = '0; a_in_tkeep = '0; a_in_tvalid = 0; a_in_tlast = 0; a_out_tready = 0;
      b_in_tdata = '0; b_in_tkeep = '0; b_in_tvalid = 0; b_in_tlast = 0; b_out_tready = 0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_valid", a_out_tvalid, 1'b0);
      check("rst_a_last",  a_out_tlast,  1'b0);
      check("rst_a_data",  a_out_tdata,  32'h0);
      check("rst_a_keep",  a_out_tkeep,  4'h0);
      check("rst_a_err",   a_err,        1'b0);
      check("rst_b_valid", b_out_tvalid, 1'b0);
      check("rst_b_keep",  b_out_tkeep,  4'h0);
      @(negedge clk) rst_n = 1'b1;
      step();
      check("rst_a_ready", a_in_tready, 1'b1);
      check("rst_b_ready", b_in_tready, 1'b1);

      // 1-beat packet: visible exactly 6 edges after its tlast edge
      a_send(32'h11, 1'b1);
      k = 0;
      while (!a_out_tvalid && k < 50) begin step(); k++; end
      check("t1_latency", 64'(k), 64'd6);
      check("t1_last", a_out_tlast, 1'b1);
      check("t1_data", a_out_tdata, 32'h11);
      check("t1_keep", a_out_tkeep, 4'hF);
      a_out_tready = 1'b1;
      step();
      a_out_tready = 1'b0;
      check("t1_valid_after_read", a_out_tvalid, 1'b0);

      // 4-beat packet with the consumer stalled
      clear_sb();
      for (int i = 0; i < 4; i++) begin
         a_send(32'hA0 + 32'(i), i == 3);
         check("t2_in_ready", a_in_tready, 1'b1);
         exp_q.push_back(32'hA0 + 32'(i)); exp_l.push_back(i == 3); exp_k.push_back(4'hF);
      end
      repeat (10) step();
      a_recv(4, 1'b0);
      compare("t2");

      // 1, 5 and 2 beat packets back to back, random consumer
      clear_sb();
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(32'hB0 + 32'(i));
         exp_l.push_back(i == 0 || i == 5 || i == 7);
         exp_k.push_back(4'hF);
      end
      fork
         begin
            for (int i = 0; i < 8; i++) a_send(32'hB0 + 32'(i), i == 0 || i == 5 || i == 7);
         end
         begin
            a_recv(8, 1'b1);
         end
      join
      compare("t3");
      repeat (10) step();
      check("t3_rel_cnt", dut_a.rel_cnt, 16'd0);
      check("t3_valid_idle", a_out_tvalid, 1'b0);

      // DEPTH=16: exactly full packet, then a blocked second packet
      clear_sb();
      for (int i = 0; i < 16; i++) begin
         b_send(32'h100 + 32'(i), 4'(i) ^ 4'h5, i == 15);
         exp_q.push_back(32'h100 + 32'(i)); exp_l.push_back(i == 15); exp_k.push_back(4'(i) ^ 4'h5);
      end
      check("t4_lat0_valid", b_out_tvalid, 1'b1);
      check("t4_ready_full", b_in_tready, 1'b0);
      b_in_tdata = 32'h200; b_in_tkeep = 4'h1; b_in_tvalid = 1'b1;
      repeat (3) step();
      check("t4_ready_held", b_in_tready, 1'b0);
      check("t4_err", b_err, 1'b0);
      b_in_tvalid = 1'b0;
      b_recv(16);
      compare("t4");
      check("t4_ready_restored", b_in_tready, 1'b1);
      check("t4_err_after", b_err, 1'b0);

      // DEPTH=16: packet longer than the FIFO
      for (int i = 0; i < 16; i++) b_send(32'h300 + 32'(i), 4'hF, 1'b0);
      check("t5_ready_full", b_in_tready, 1'b0);
      repeat (2) step();
      check("t5_err", b_err, 1'b1);
      check("t5_valid", b_out_tvalid, 1'b0);

      // reset in the middle of a packet
      for (int i = 0; i < 3; i++) a_send(32'hD0 + 32'(i), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_a_valid", a_out_tvalid, 1'b0);
      check("t6_a_err", a_err, 1'b0);
      check("t6_a_data", a_out_tdata, 32'h0);
      check("t6_b_err", b_err, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      step();
      check("t6_a_ready", a_in_tready, 1'b1);
      clear_sb();
      a_send(32'hC0, 1'b0);
      a_send(32'hC1, 1'b1);
      exp_q.push_back(32'hC0); exp_l.push_back(1'b0); exp_k.push_back(4'hF);
      exp_q.push_back(32'hC1); exp_l.push_back(1'b1); exp_k.push_back(4'hF);
      a_recv(2, 1'b0);
      compare("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_packet_long_fifo_sc.md
Name: axis_packet_long_fifo_sc

Overview:
- Single-clock, store-and-forward AXI-Stream packet FIFO for long packets (thousands of beats).
- A packet is only presented on the output after its last beat has been written and a fixed release latency has elapsed.
- Output tlast is regenerated from stored packet lengths, not stored per word.
- Sits between a bursty producer and a consumer that needs whole packets back-to-back.

Parameters:
- DSIZE, 32: tdata width in bits.
- KSIZE, DSIZE/8: tkeep width in bits.
- USE_KEEP, 0: 1 = tkeep is stored alongside tdata; 0 = tkeep is not stored and out_tkeep is driven all-ones.
- DEPTH, 8192: data FIFO depth in words; power of 2, at least 16.
- PKT_DEPTH, 4: packet-length FIFO depth; values below 4 are forced to 4.
- REL_LAT, 6: extra cycles before a completed packet becomes readable; 0 or more.

Ports:
- aclk, in, 1: clock; all logic is on its rising edge.
- aresetn, in, 1: asynchronous active-low reset.
- in_tdata, in, DSIZE: write data.
- in_tkeep, in, KSIZE: write keep.
- in_tvalid, in, 1: write valid.
- in_tlast, in, 1: last beat of packet.
- in_tready, out, 1: FIFO can accept a beat.
- out_tdata, out, DSIZE: head word.
- out_tkeep, out, KSIZE: head keep.
- out_tvalid, out, 1: a complete packet is readable.
- out_tlast, out, 1: head word is the last word of its packet.
- out_tready, in, 1: consumer accepts.
- err_too_long, out, 1: sticky error, packet cannot fit in the FIFO.

Behaviour:
- Handshakes: write fires when in_tvalid && in_tready; read fires when out_tvalid && out_tready.
- in_tready = !data_full && !pkt_full. It is purely combinational and does not depend on in_tvalid.
- Data FIFO: DEPTH words, first-word-fall-through. out_tdata/out_tkeep show the head word whenever the FIFO is non-empty.
  - Simultaneous write and read in one cycle are both performed; occupancy is unchanged.
  - Pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty on wrap-around.
- Write beat counter w_cnt (16 bits):
  - Increments on each write.
  - Clears to 0 on a write with in_tlast.
- On a write with in_tlast, {len_is_1 = (w_cnt==0), len_m1 = w_cnt} is pushed into the packet-length FIFO.
- Release delay:
  - The tlast write pulse enters a REL_LAT-stage shift register.
  - Its output increments rel_cnt.
  - A tlast read decrements rel_cnt; both in one cycle leaves it unchanged.
  - Timing: tlast accepted at edge N makes the packet countable after edge N+REL_LAT (REL_LAT=0: after edge N).
- out_tvalid = (rel_cnt != 0) && !pkt_empty && !data_empty.
- Read beat counter r_cnt (16 bits):
  - Increments on each read.
  - Clears to 0 on a read with out_tlast.
- out_tlast = len_is_1 || (r_cnt == len_m1), using the packet-length FIFO head. The length FIFO pops on a read with out_tlast.
- Packet length is limited to min(DEPTH, 65536) beats.
- err_too_long:
  - Set when data_full && rel_cnt==0 && w_cnt!=0 (FIFO full with no complete packet).
  - Stays set until reset. The FIFO then stalls; no data is dropped.
- Reset, asynchronous and taking effect immediately (including mid-packet):
  - All pointers, counters, the delay line and err_too_long are cleared.
  - The FIFO becomes empty: out_tvalid=0, out_tlast=0, out_tdata=0, out_tkeep=0.
  - in_tready=1 once the reset is released.
  - A partially written packet is discarded.

Decomposition:
- Package axis_pkt_fifo_pkg holds:
  - typedef len_t (logic [15:0]).
  - typedef pkt_desc_t (struct: len_is_1, len_m1).
  - Function clog2-based address-width helper.
- Sub-module sc_delay_line (parameters LAT, DSIZE; async active-low reset; LAT=0 is a pass-through) implements the release shift register.
- The data FIFO and the length FIFO are the same generic sync_fifo_fwft instance with different widths.

Test Plan:
- One 1-beat packet, REL_LAT=6, tlast written at edge 10:
  - out_tvalid first high after edge 16, with out_tlast=1.
  - After the read, out_tvalid=0.
- 4-beat packet 0xA0..0xA3 with out_tready held low:
  - in_tready stays 1.
  - Releasing out_tready delivers A0..A3 in order, with out_tlast only on A3.
- Three back-to-back packets of 1, 5 and 2 beats with random out_tready:
  - Data order is preserved.
  - out_tlast occurs on output beats 1, 6 and 8.
  - The final rel_cnt is 0.
- DEPTH=16, 16-beat packet then a second packet with no reads:
  - in_tready falls after the 16th write.
  - Reading the first packet restores in_tready.
  - err_too_long stays 0.
- DEPTH=16, 20-beat packet:
  - in_tready falls after 16 beats and err_too_long becomes 1.
  - out_tvalid stays 0.
- Reset asserted mid-packet (3 of 8 beats written):
  - out_tvalid=0 and err_too_long=0.
  - A subsequent 2-beat packet is delivered correctly.
